// File: rtl/draw_pkg.sv
// -----------------------------------------------------------------------------
// draw_pkg
//   Shared definitions for the draw command path.
//   - sched_state_t : scheduler FSM encoding (3 bits).
//   - A_REQ_ON_COUNT / A_REQ_OFF_COUNT : register-block addresses of the
//     ON/OFF window length registers that feed the scheduler.
// -----------------------------------------------------------------------------
package draw_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_HALT  = 3'd4
    } sched_state_t;

    localparam logic [7:0] A_REQ_ON_COUNT  = 8'h20;
    localparam logic [7:0] A_REQ_OFF_COUNT = 8'h24;

endpackage

// File: rtl/draw_req_window.sv
// -----------------------------------------------------------------------------
// draw_req_window
//   ON/OFF duty window that throttles RBUF fetches.
//   Ports:
//     CLK      in   clock
//     RST      in   synchronous clear, active-high
//     EN       in   window runs while high; forced to ON/counter 0 when low
//     ON_CNT   in   ON-phase length in cycles (0 = throttling off)
//     OFF_CNT  in   OFF-phase length in cycles (0 = throttling off)
//     REQ_EN   out  window currently ON (only meaningful while EN=1)
// -----------------------------------------------------------------------------
module draw_req_window #(
    parameter int CNT_W = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [CNT_W-1:0] ON_CNT,
    input  logic [CNT_W-1:0] OFF_CNT,
    output logic             REQ_EN
);

    logic             phase_on_reg;
    logic [CNT_W-1:0] cnt_reg;
    // Length of the phase in progress, captured when the phase begins so that
    // register writes during a phase only affect the following phase.
    logic [CNT_W-1:0] len_reg;

    logic throttle_off;
    logic phase_end;

    assign throttle_off = (ON_CNT == '0) || (OFF_CNT == '0);
    // A captured length of 0 (count changed after capture) ends the phase at
    // once instead of letting the counter run to its maximum.
    assign phase_end    = (len_reg == '0) || (cnt_reg == len_reg - CNT_W'(1));

    always_ff @(posedge CLK) begin
        if (RST || !EN || throttle_off) begin
            // While idle the ON length tracks the register so the first ON
            // phase uses the value present when the scheduler starts.
            phase_on_reg <= 1'b1;
            cnt_reg      <= '0;
            len_reg      <= ON_CNT;
        end else if (phase_end) begin
            phase_on_reg <= !phase_on_reg;
            cnt_reg      <= '0;
            len_reg      <= phase_on_reg ? OFF_CNT : ON_CNT;
        end else begin
            cnt_reg      <= cnt_reg + CNT_W'(1);
        end
    end

    assign REQ_EN = EN && (phase_on_reg || throttle_off);

endmodule

// File: rtl/draw_cmd_sched.sv
// -----------------------------------------------------------------------------
// draw_cmd_sched
//   Pops 32-bit commands from the read buffer and hands each one to the draw
//   decoder over valid/ready. Started by EXE_FLAG, stopped by INIT_REG, halted
//   by decoder error. Fetches are throttled by an ON/OFF duty window.
//   Ports:
//     CLK, RST, INIT           clock, sync reset, sync soft clear (same effect)
//     EXE_FLAG, INIT_REG       1-cycle start / stop pulses
//     ERR_IN                   decoder error level
//     REQ_ON_COUNT/OFF_COUNT   window lengths (0 = no throttling)
//     RBUF_EMPTY, RBUF_RDATA   read buffer status / data (RD_LAT after pop)
//     RBUF_RD                  1-cycle pop strobe
//     DEC_READY/VALID/CMD      decoder handshake
//     WORKINGDRW               active (FETCH/WAIT/ISSUE)
//     REQ_EN                   window ON
//     SCHED_ERR                sticky halt flag
// -----------------------------------------------------------------------------
module draw_cmd_sched
    import draw_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 10,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              INIT,
    input  logic              EXE_FLAG,
    input  logic              INIT_REG,
    input  logic              ERR_IN,
    input  logic [CNT_W-1:0]  REQ_ON_COUNT,
    input  logic [CNT_W-1:0]  REQ_OFF_COUNT,
    input  logic              RBUF_EMPTY,
    input  logic [DATA_W-1:0] RBUF_RDATA,
    output logic              RBUF_RD,
    input  logic              DEC_READY,
    output logic              DEC_VALID,
    output logic [DATA_W-1:0] DEC_CMD,
    output logic              WORKINGDRW,
    output logic              REQ_EN,
    output logic              SCHED_ERR
);

    sched_state_t      state_reg;
    logic              stop_pend_reg;
    logic [RD_LAT-1:0] lat_sr_reg;
    logic [RD_LAT-1:0] lat_sr_next;
    logic              dec_valid_reg;
    logic [DATA_W-1:0] dec_cmd_reg;
    logic              working_reg;
    logic              sched_err_reg;

    logic clr;
    logic req_en;
    logic pop;

    assign clr = RST || INIT;

    draw_req_window #(
        .CNT_W (CNT_W)
    ) u_req_window (
        .CLK     (CLK),
        .RST     (clr),
        .EN      (working_reg),
        .ON_CNT  (REQ_ON_COUNT),
        .OFF_CNT (REQ_OFF_COUNT),
        .REQ_EN  (req_en)
    );

    // One-hot latency tracker: bit 0 is set on the pop, the token walks up one
    // bit per WAIT cycle, and the top bit marks the cycle RBUF_RDATA is valid.
    assign lat_sr_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_lat_shift
            assign lat_sr_next[gi] = lat_sr_reg[gi-1];
        end
    endgenerate

    // The pop is decided in the same cycle as RBUF_EMPTY is seen, so the strobe
    // can never fire on an empty buffer. Error and stop take precedence.
    assign pop = (state_reg == S_FETCH) && req_en && !RBUF_EMPTY &&
                 !ERR_IN && !INIT_REG && !clr;

    always_ff @(posedge CLK) begin
        if (clr) begin
            state_reg     <= S_IDLE;
            stop_pend_reg <= 1'b0;
            lat_sr_reg    <= '0;
            dec_valid_reg <= 1'b0;
            dec_cmd_reg   <= '0;
            working_reg   <= 1'b0;
            sched_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (EXE_FLAG && !INIT_REG) begin
                        state_reg     <= S_FETCH;
                        working_reg   <= 1'b1;
                        stop_pend_reg <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (ERR_IN) begin
                        state_reg     <= S_HALT;
                        working_reg   <= 1'b0;
                        sched_err_reg <= 1'b1;
                    end else if (INIT_REG) begin
                        state_reg     <= S_IDLE;
                        working_reg   <= 1'b0;
                    end else if (pop) begin
                        state_reg     <= S_WAIT;
                        lat_sr_reg    <= RD_LAT'(1);
                    end
                end
                S_WAIT: begin
                    if (ERR_IN) begin
                        state_reg     <= S_HALT;
                        working_reg   <= 1'b0;
                        sched_err_reg <= 1'b1;
                    end else begin
                        // A stop here is deferred: the popped command must
                        // still reach the decoder.
                        if (INIT_REG) begin
                            stop_pend_reg <= 1'b1;
                        end
                        if (lat_sr_reg[RD_LAT-1]) begin
                            dec_cmd_reg   <= RBUF_RDATA;
                            dec_valid_reg <= 1'b1;
                            state_reg     <= S_ISSUE;
                        end else begin
                            lat_sr_reg    <= lat_sr_next;
                        end
                    end
                end
                S_ISSUE: begin
                    if (ERR_IN) begin
                        state_reg     <= S_HALT;
                        working_reg   <= 1'b0;
                        dec_valid_reg <= 1'b0;
                        sched_err_reg <= 1'b1;
                    end else if (DEC_READY) begin
                        dec_valid_reg <= 1'b0;
                        if (stop_pend_reg || INIT_REG) begin
                            state_reg     <= S_IDLE;
                            working_reg   <= 1'b0;
                            stop_pend_reg <= 1'b0;
                        end else begin
                            state_reg     <= S_FETCH;
                        end
                    end else if (INIT_REG) begin
                        stop_pend_reg <= 1'b1;
                    end
                end
                S_HALT: begin
                    // Sticky until RST/INIT.
                    state_reg <= S_HALT;
                end
                default: begin
                    state_reg     <= S_IDLE;
                    working_reg   <= 1'b0;
                    dec_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign RBUF_RD    = pop;
    assign DEC_VALID  = dec_valid_reg;
    assign DEC_CMD    = dec_cmd_reg;
    assign WORKINGDRW = working_reg;
    assign REQ_EN     = req_en;
    assign SCHED_ERR  = sched_err_reg;

endmodule

// File: tb/tb_draw_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_draw_cmd_sched
//   Directed bench for draw_cmd_sched (DATA_W=32, CNT_W=10, RD_LAT=1).
//   A cycle table covers the basic flow, error in FETCH and same-cycle
//   start/stop; hand sequences cover backpressure, window, deferred stop,
//   error in WAIT and reset in ISSUE.
// -----------------------------------------------------------------------------
module tb_draw_cmd_sched;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        INIT = 1'b0;
    logic        EXE_FLAG = 1'b0;
    logic        INIT_REG = 1'b0;
    logic        ERR_IN = 1'b0;
    logic [9:0]  REQ_ON_COUNT = '0;
    logic [9:0]  REQ_OFF_COUNT = '0;
    logic        RBUF_EMPTY;
    logic [31:0] RBUF_RDATA = '0;
    logic        RBUF_RD;
    logic        DEC_READY = 1'b0;
    logic        DEC_VALID;
    logic [31:0] DEC_CMD;
    logic        WORKINGDRW;
    logic        REQ_EN;
    logic        SCHED_ERR;

    always #5 CLK = ~CLK;

    draw_cmd_sched #(
        .DATA_W (32),
        .CNT_W  (10),
        .RD_LAT (1)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .INIT          (INIT),
        .EXE_FLAG      (EXE_FLAG),
        .INIT_REG      (INIT_REG),
        .ERR_IN        (ERR_IN),
        .REQ_ON_COUNT  (REQ_ON_COUNT),
        .REQ_OFF_COUNT (REQ_OFF_COUNT),
        .RBUF_EMPTY    (RBUF_EMPTY),
        .RBUF_RDATA    (RBUF_RDATA),
        .RBUF_RD       (RBUF_RD),
        .DEC_READY     (DEC_READY),
        .DEC_VALID     (DEC_VALID),
        .DEC_CMD       (DEC_CMD),
        .WORKINGDRW    (WORKINGDRW),
        .REQ_EN        (REQ_EN),
        .SCHED_ERR     (SCHED_ERR)
    );

    // ---------------- read buffer model (latency 1) ----------------
    logic [31:0] mem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    bit          inf_mode = 1'b0;
    logic [31:0] inf_seq = 32'h3000_0000;

    assign RBUF_EMPTY = inf_mode ? 1'b0 : (rd_ptr == wr_ptr);

    always @(posedge CLK) begin
        if (RBUF_RD) begin
            if (inf_mode) begin
                RBUF_RDATA <= inf_seq;
                inf_seq    <= inf_seq + 32'd1;
            end else if (rd_ptr != wr_ptr) begin
                RBUF_RDATA <= mem[rd_ptr % 64];
                rd_ptr     <= rd_ptr + 1;
            end
        end
    end

    // ---------------- monitors ----------------
    int          hs_cnt = 0;
    logic [31:0] hs_last = '0;
    int          pop_cnt = 0;
    int          viol_empty = 0;
    int          viol_window = 0;

    always @(posedge CLK) begin
        if (DEC_VALID && DEC_READY) begin
            hs_cnt  <= hs_cnt + 1;
            hs_last <= DEC_CMD;
        end
    end

    always @(negedge CLK) begin
        if (RBUF_RD) pop_cnt <= pop_cnt + 1;
        if (RBUF_RD && RBUF_EMPTY) viol_empty <= viol_empty + 1;
        if (RBUF_RD && !REQ_EN) viol_window <= viol_window + 1;
    end

    // ---------------- check helpers ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok %s = 0x%08h", name, act);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        mem[wr_ptr % 64] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        EXE_FLAG = 1'b0; INIT_REG = 1'b0; ERR_IN = 1'b0; INIT = 1'b0;
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        wr_ptr = rd_ptr;
    endtask

    task automatic pulse_exe();
        EXE_FLAG = 1'b1;
        cyc();
        EXE_FLAG = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (DEC_VALID) ok = 1'b1;
            else cyc();
        end
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        logic        exe, ireg, err, init, rdy;
        logic        e_wk, e_v, e_rd, e_se, e_ren;
        logic [31:0] e_cmd;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic [4:0] in, input logic [4:0] ex, input logic [31:0] c);
        vec_t v;
        {v.exe, v.ireg, v.err, v.init, v.rdy}   = in;
        {v.e_wk, v.e_v, v.e_rd, v.e_se, v.e_ren} = ex;
        v.e_cmd = c;
        return v;
    endfunction

    localparam logic [31:0] CA = 32'hA000_0001;
    localparam logic [31:0] CB = 32'hB000_0002;
    localparam logic [31:0] CC = 32'hC000_0003;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          bad;
        int          hs0;
        int          pop0;
        logic [31:0] first;

        // inputs {exe,ireg,err,init,rdy}  expected {wk,v,rd,se,ren}
        tbl[0]  = mk(5'b10001, 5'b00000, '0);
        tbl[1]  = mk(5'b00001, 5'b10101, '0);
        tbl[2]  = mk(5'b00001, 5'b10001, '0);
        tbl[3]  = mk(5'b00001, 5'b11001, CA);
        tbl[4]  = mk(5'b00001, 5'b10101, '0);
        tbl[5]  = mk(5'b00001, 5'b10001, '0);
        tbl[6]  = mk(5'b00001, 5'b11001, CB);
        tbl[7]  = mk(5'b00001, 5'b10101, '0);
        tbl[8]  = mk(5'b00001, 5'b10001, '0);
        tbl[9]  = mk(5'b00001, 5'b11001, CC);
        tbl[10] = mk(5'b00001, 5'b10001, '0);   // RBUF empty: waits in FETCH
        tbl[11] = mk(5'b00001, 5'b10001, '0);
        tbl[12] = mk(5'b00101, 5'b10001, '0);   // error in FETCH
        tbl[13] = mk(5'b10001, 5'b00010, '0);   // HALT, EXE ignored
        tbl[14] = mk(5'b00011, 5'b00010, '0);   // INIT clears
        tbl[15] = mk(5'b11001, 5'b00000, '0);   // EXE+INIT_REG together in IDLE
        tbl[16] = mk(5'b00001, 5'b00000, '0);
        tbl[17] = mk(5'b00001, 5'b00000, '0);

        // ---- reset state ----
        REQ_ON_COUNT = 10'd0; REQ_OFF_COUNT = 10'd0; DEC_READY = 1'b1;
        cyc();
        do_reset();
        chk("reset_outputs", {27'd0, RBUF_RD, DEC_VALID, WORKINGDRW, REQ_EN, SCHED_ERR}, 32'd0);
        chk("reset_cmd", DEC_CMD, 32'd0);

        // ---- table: basic flow, error in FETCH, same-cycle EXE/INIT_REG ----
        push(CA); push(CB); push(CC);
        for (int i = 0; i < 18; i++) begin
            EXE_FLAG = tbl[i].exe; INIT_REG = tbl[i].ireg; ERR_IN = tbl[i].err;
            INIT = tbl[i].init; DEC_READY = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_flags", i),
                {27'd0, WORKINGDRW, DEC_VALID, RBUF_RD, SCHED_ERR, REQ_EN},
                {27'd0, tbl[i].e_wk, tbl[i].e_v, tbl[i].e_rd, tbl[i].e_se, tbl[i].e_ren});
            if (tbl[i].e_v) chk($sformatf("tbl%0d_cmd", i), DEC_CMD, tbl[i].e_cmd);
            @(posedge CLK); #1;
        end
        EXE_FLAG = 1'b0; INIT_REG = 1'b0; ERR_IN = 1'b0; INIT = 1'b0;
        chk("tbl_handshakes", hs_cnt, 32'd3);

        // ---- backpressure ----
        do_reset();
        push(32'h2222_0001); push(32'h2222_0002);
        DEC_READY = 1'b0;
        hs0 = hs_cnt;
        pulse_exe();
        wait_valid("bp_valid_seen");
        first = 32'h2222_0001;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (!DEC_VALID || DEC_CMD !== first || RBUF_RD) bad++;
            cyc();
        end
        chk("bp_stable_bad_cycles", bad, 32'd0);
        DEC_READY = 1'b1;
        #1;
        chk("bp_valid_at_hs", {31'd0, DEC_VALID}, 32'd1);
        cyc();
        chk("bp_next_pop", {31'd0, RBUF_RD}, 32'd1);
        chk("bp_hs_count", hs_cnt - hs0, 32'd1);
        chk("bp_hs_data", hs_last, first);

        // ---- window ON=4 OFF=6, buffer always full ----
        REQ_ON_COUNT = 10'd4; REQ_OFF_COUNT = 10'd6;
        do_reset();
        inf_mode = 1'b1;
        DEC_READY = 1'b1;
        pulse_exe();
        pop0 = pop_cnt;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (REQ_EN !== ((k % 10) < 4) || !WORKINGDRW) bad++;
            cyc();
        end
        chk("win_pattern_bad_cycles", bad, 32'd0);
        chk("win_pop_count", pop_cnt - pop0, 32'd8);
        chk("win_pop_while_off", viol_window, 32'd0);
        inf_mode = 1'b0;
        REQ_ON_COUNT = 10'd0; REQ_OFF_COUNT = 10'd0;

        // ---- stop while issuing, decoder late by 3 cycles ----
        do_reset();
        push(32'h4444_0001); push(32'h4444_0002);
        DEC_READY = 1'b0;
        hs0 = hs_cnt;
        pulse_exe();
        wait_valid("stop_valid_seen");
        INIT_REG = 1'b1;
        cyc();
        INIT_REG = 1'b0;
        cyc();
        cyc();
        DEC_READY = 1'b1;
        #1;
        chk("stop_still_valid", {31'd0, DEC_VALID}, 32'd1);
        chk("stop_cmd", DEC_CMD, 32'h4444_0001);
        cyc();
        chk("stop_idle_flags", {29'd0, WORKINGDRW, DEC_VALID, RBUF_RD}, 32'd0);
        cyc(); cyc();
        chk("stop_stays_idle", {31'd0, WORKINGDRW}, 32'd0);
        chk("stop_hs_count", hs_cnt - hs0, 32'd1);
        pulse_exe();
        chk("stop_restart_pop", {31'd0, RBUF_RD}, 32'd1);
        wait_valid("stop_restart_valid");
        chk("stop_restart_cmd", DEC_CMD, 32'h4444_0002);

        // ---- error in WAIT ----
        do_reset();
        push(32'h5555_0001);
        DEC_READY = 1'b1;
        hs0 = hs_cnt;
        pulse_exe();
        chk("err_pop", {31'd0, RBUF_RD}, 32'd1);
        cyc();                      // now in WAIT
        ERR_IN = 1'b1;
        cyc();
        ERR_IN = 1'b0;
        chk("err_halt_flags", {29'd0, SCHED_ERR, DEC_VALID, WORKINGDRW}, 32'd4);
        pulse_exe();
        cyc();
        chk("err_exe_ignored", {29'd0, SCHED_ERR, DEC_VALID, WORKINGDRW}, 32'd4);
        INIT = 1'b1;
        cyc();
        INIT = 1'b0;
        chk("err_init_clears", {30'd0, SCHED_ERR, WORKINGDRW}, 32'd0);
        chk("err_no_delivery", hs_cnt - hs0, 32'd0);

        // ---- RST while issuing ----
        do_reset();
        push(32'h6666_0001);
        DEC_READY = 1'b0;
        pulse_exe();
        wait_valid("rst_valid_seen");
        chk("rst_cmd_before", DEC_CMD, 32'h6666_0001);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        chk("rst_outputs", {27'd0, RBUF_RD, DEC_VALID, WORKINGDRW, REQ_EN, SCHED_ERR}, 32'd0);
        chk("rst_cmd_cleared", DEC_CMD, 32'd0);

        // ---- whole-run invariant ----
        chk("pop_on_empty", viol_empty, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
